// File: rtl/dma_ext_pattern_pkg.sv
// Shared types and the word-pattern helper for the stream-pattern DMA extension.
package dma_ext_pattern_pkg;

    localparam int WordWidth = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_XOR = 1'b1
    } mode_e;

    // Word j of a beat: in_word OP (base + j*stride), all modulo 2^32.
    function automatic logic [WordWidth-1:0] pattern_word(
        input logic [WordWidth-1:0] in_word,
        input logic [WordWidth-1:0] base,
        input int                   j,
        input logic [WordWidth-1:0] stride,
        input mode_e                mode
    );
        logic [WordWidth-1:0] key;
        key = base + WordWidth'(j) * stride;
        return (mode == MODE_XOR) ? (in_word ^ key) : (in_word + key);
    endfunction

endpackage

// File: rtl/dma_ext_skid_buf.sv
// Two-entry valid/ready buffer: registered output (1-cycle latency), full
// throughput, head held on the output while stalled and after draining.
module dma_ext_skid_buf #(
    parameter int Width = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [Width-1:0] i_in_bits,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [Width-1:0] o_out_bits,
    output logic             o_full
);

    logic [1:0]       r_count;
    logic [Width-1:0] r_head;
    logic [Width-1:0] r_tail;
    logic             w_enq;
    logic             w_deq;

    assign o_in_ready  = (r_count != 2'd2);
    assign o_full      = (r_count == 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign o_out_bits  = r_head;
    assign w_enq       = i_in_valid && o_in_ready;
    assign w_deq       = o_out_valid && i_out_ready;

    // Occupancy and head register; head only moves on enqueue-into-empty,
    // simultaneous enq/deq, or promotion of the tail.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values and simulation matches hardware.
        if (i_rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
        end else begin
            case ({w_enq, w_deq})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_in_bits;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: r_head <= i_in_bits;
                default: ;
            endcase
        end
    end

    // Tail (skid) slot captures a beat arriving while the head is occupied.
    always_ff @(posedge i_clk) begin
        // NOTE: the tail is pure data qualified by r_count, so it carries no
        // reset; this keeps the wide datapath free of reset fan-out.
        if (w_enq && !w_deq && (r_count == 2'd1)) begin
            r_tail <= i_in_bits;
        end
    end

endmodule

// File: rtl/dma_ext_stream_pattern.sv
// Stream-pattern DMA extension: overlays an incrementing 32-bit word pattern
// (add or XOR, per-word stride) on a programmed number of beats.
// Optional build macro DMA_EXT_PATTERN_PERF_EN adds ext_stall_cnt_o.
module dma_ext_stream_pattern
    import dma_ext_pattern_pkg::*;
#(
    parameter int DataWidth = 512,
    parameter int CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 ext_data_i_ready,
    input  logic                 ext_data_i_valid,
    input  logic [DataWidth-1:0] ext_data_i_bits,
    input  logic                 ext_data_o_ready,
    output logic                 ext_data_o_valid,
    output logic [DataWidth-1:0] ext_data_o_bits,
    input  logic [31:0]          ext_csr_i_0,
    input  logic [31:0]          ext_csr_i_1,
    input  logic [31:0]          ext_csr_i_2,
    input  logic [31:0]          ext_csr_i_3,
    input  logic                 ext_start_i,
    output logic                 ext_busy_o
`ifdef DMA_EXT_PATTERN_PERF_EN
    ,
    output logic [31:0]          ext_stall_cnt_o
`endif
);

    localparam int NW = DataWidth / WordWidth;

    state_e                 r_state;
    logic                   r_busy;
    logic [WordWidth-1:0]   r_base;
    logic [WordWidth-1:0]   r_stride;
    logic [CntWidth-1:0]    r_n;
    logic [CntWidth-1:0]    r_in_cnt;
    mode_e                  r_mode;

    logic                   w_sb_in_valid;
    logic                   w_sb_in_ready;
    logic                   w_sb_full;
    logic                   w_in_hs;
    logic                   w_drain_done;
    logic [DataWidth-1:0]   w_pat_bits;
    logic                   w_unused_csr;

    // Upstream is only accepted while running and the buffer has room.
    assign w_sb_in_valid    = ext_data_i_valid && (r_state == RUN);
    assign ext_data_i_ready = (r_state == RUN) && w_sb_in_ready;
    assign w_in_hs          = w_sb_in_valid && w_sb_in_ready;
    assign ext_busy_o       = r_busy;

    // The buffer is empty after this edge if it holds nothing, or holds one
    // beat that is being taken now (no enqueue can happen in DRAIN).
    assign w_drain_done = !w_sb_full && (!ext_data_o_valid || ext_data_o_ready);

    assign w_unused_csr = ^ext_csr_i_3[31:1];

    // Apply the pattern to every word of the incoming beat.
    always_comb begin
        // NOTE: a default assignment before the loop guarantees every bit is
        // written on every pass, so no latch can be inferred.
        w_pat_bits = '0;
        for (int j = 0; j < NW; j++) begin
            w_pat_bits[j*WordWidth +: WordWidth] =
                pattern_word(ext_data_i_bits[j*WordWidth +: WordWidth],
                             r_base, j, r_stride, r_mode);
        end
    end

    // Job control FSM: latches the CSRs on start and tracks pattern base and
    // accepted-beat count; busy is registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_base   <= '0;
            r_stride <= '0;
            r_n      <= '0;
            r_in_cnt <= '0;
            r_mode   <= MODE_ADD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ext_start_i) begin
                        r_base   <= ext_csr_i_0;
                        r_stride <= ext_csr_i_1;
                        r_n      <= ext_csr_i_2[CntWidth-1:0];
                        r_mode   <= mode_e'(ext_csr_i_3[0]);
                        r_in_cnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= (ext_csr_i_2[CntWidth-1:0] != '0) ? RUN : DRAIN;
                    end
                end
                RUN: begin
                    if (w_in_hs) begin
                        r_base   <= r_base + WordWidth'(NW) * r_stride;
                        r_in_cnt <= r_in_cnt + CntWidth'(1);
                        if (r_in_cnt + CntWidth'(1) == r_n) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    dma_ext_skid_buf #(
        .Width (DataWidth)
    ) u_skid (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_in_valid  (w_sb_in_valid),
        .o_in_ready  (w_sb_in_ready),
        .i_in_bits   (w_pat_bits),
        .o_out_valid (ext_data_o_valid),
        .i_out_ready (ext_data_o_ready),
        .o_out_bits  (ext_data_o_bits),
        .o_full      (w_sb_full)
    );

`ifdef DMA_EXT_PATTERN_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count RUN cycles where upstream offers a beat but the buffer is full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && ext_start_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == RUN) && ext_data_i_valid && !ext_data_i_ready
                     && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign ext_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dma_ext_stream_pattern.sv
// Directed self-checking bench for dma_ext_stream_pattern (default parameters).
module tb_dma_ext_stream_pattern;

    localparam int DW = 512;
    localparam int NW = DW / 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ext_data_i_ready;
    logic          ext_data_i_valid;
    logic [DW-1:0] ext_data_i_bits;
    logic          ext_data_o_ready;
    logic          ext_data_o_valid;
    logic [DW-1:0] ext_data_o_bits;
    logic [31:0]   ext_csr_i_0;
    logic [31:0]   ext_csr_i_1;
    logic [31:0]   ext_csr_i_2;
    logic [31:0]   ext_csr_i_3;
    logic          ext_start_i;
    logic          ext_busy_o;
`ifdef DMA_EXT_PATTERN_PERF_EN
    logic [31:0]   ext_stall_cnt_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [DW-1:0] got[$];

    always #5 clk_i = ~clk_i;

    dma_ext_stream_pattern dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ext_data_i_ready (ext_data_i_ready),
        .ext_data_i_valid (ext_data_i_valid),
        .ext_data_i_bits  (ext_data_i_bits),
        .ext_data_o_ready (ext_data_o_ready),
        .ext_data_o_valid (ext_data_o_valid),
        .ext_data_o_bits  (ext_data_o_bits),
        .ext_csr_i_0      (ext_csr_i_0),
        .ext_csr_i_1      (ext_csr_i_1),
        .ext_csr_i_2      (ext_csr_i_2),
        .ext_csr_i_3      (ext_csr_i_3),
        .ext_start_i      (ext_start_i),
        .ext_busy_o       (ext_busy_o)
`ifdef DMA_EXT_PATTERN_PERF_EN
        ,
        .ext_stall_cnt_o  (ext_stall_cnt_o)
`endif
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Expected beat b: word j = in OP (seed + (b*NW + j)*stride).
    function automatic logic [DW-1:0] exp_beat(input logic [31:0] seed, input logic [31:0] stride,
                                               input logic mode, input logic [7:0] in_byte, input int b);
        logic [DW-1:0] r;
        logic [31:0]   iw;
        logic [31:0]   k;
        iw = {4{in_byte}};
        for (int j = 0; j < NW; j++) begin
            k = seed + 32'(b * NW + j) * stride;
            r[j*32 +: 32] = mode ? (iw ^ k) : (iw + k);
        end
        return r;
    endfunction

    // Runs one job, modelling buffer occupancy and checking every cycle.
    task automatic run_job(input logic [31:0] seed, input logic [31:0] stride, input int n,
                           input logic mode, input logic [7:0] in_byte, input int rdy_pct,
                           input int restart_cyc, input string name);
        int sent, emitted, occ, cyc, stalls;
        logic done, prev_v, prev_rdy, v, ir, bz, ordy, ivld;
        logic [DW-1:0] b, prev_b, last_b;
        sent = 0; emitted = 0; occ = 0; cyc = 0; stalls = 0;
        done = 1'b0; prev_v = 1'b0; prev_rdy = 1'b1; prev_b = '0; last_b = '0;
        got.delete();
        ext_csr_i_0 = seed;
        ext_csr_i_1 = stride;
        ext_csr_i_2 = 32'(n);
        ext_csr_i_3 = {31'h7FFF_FFFF, mode};
        ext_data_i_valid = 1'b0;
        ext_data_o_ready = 1'b1;
        ext_data_i_bits  = {(DW/8){in_byte}};
        ext_start_i = 1'b1;
        step();
        ext_start_i = 1'b0;
        while (1) begin
            v  = ext_data_o_valid;
            b  = ext_data_o_bits;
            ir = ext_data_i_ready;
            bz = ext_busy_o;
            if (done) begin
                tests_run++;
                if (bz !== 1'b0 || v !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s_busy_drop: busy=%b valid=%b, required busy=0 valid=0", name, bz, v);
                end
                tests_run++;
                if (b !== last_b) begin
                    tests_failed++;
                    $display("FAIL %s_hold_bits: got %h required %h", name, b, last_b);
                end
                break;
            end
            if (cyc >= 400) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s_timeout: emitted %0d beats, required %0d", name, emitted, n);
                break;
            end
            tests_run++;
            if (v !== (occ != 0)) begin
                tests_failed++;
                $display("FAIL %s_out_valid cyc%0d: got %b required %b", name, cyc, v, occ != 0);
            end
            tests_run++;
            if (ir !== (occ < 2 && sent < n)) begin
                tests_failed++;
                $display("FAIL %s_in_ready cyc%0d: got %b required %b", name, cyc, ir, (occ < 2 && sent < n));
            end
            tests_run++;
            if (bz !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_busy cyc%0d: got %b required 1", name, cyc, bz);
            end
            if (prev_v && !prev_rdy) begin
                tests_run++;
                if (v !== 1'b1 || b !== prev_b) begin
                    tests_failed++;
                    $display("FAIL %s_stall_stable cyc%0d: valid=%b bits %h required %h", name, cyc, v, b, prev_b);
                end
            end
            ordy = ($urandom_range(99) < rdy_pct);
            ivld = (sent < n);
            ext_data_o_ready = ordy;
            ext_data_i_valid = ivld;
            if (cyc == restart_cyc) begin
                ext_csr_i_0 = seed ^ 32'h0000_FFFF;
                ext_csr_i_1 = stride + 32'd7;
                ext_csr_i_2 = 32'(n + 3);
                ext_csr_i_3 = {31'd0, ~mode};
                ext_start_i = 1'b1;
            end
            step();
            ext_start_i = 1'b0;
            if (ivld && !ir) stalls++;
            if (ivld && ir) begin
                sent++;
                occ++;
            end
            if (v && ordy) begin
                got.push_back(b);
                tests_run++;
                if (b !== exp_beat(seed, stride, mode, in_byte, emitted)) begin
                    tests_failed++;
                    $display("FAIL %s_beat%0d: got %h required %h", name, emitted, b,
                             exp_beat(seed, stride, mode, in_byte, emitted));
                end
                last_b = b;
                emitted++;
                occ--;
                if (emitted == n) done = 1'b1;
            end
            prev_v = v; prev_rdy = ordy; prev_b = b;
            cyc++;
        end
        // Nothing further may be accepted or emitted once the job is over.
        ext_data_i_valid = 1'b1;
        ext_data_o_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (ext_data_o_valid !== 1'b0 || ext_data_i_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_idle_quiet: valid=%b ready=%b required 0/0", name, ext_data_o_valid, ext_data_i_ready);
            end
        end
        ext_data_i_valid = 1'b0;
        tests_run++;
        if (got.size() != n) begin
            tests_failed++;
            $display("FAIL %s_beat_count: got %0d required %0d", name, got.size(), n);
        end
`ifdef DMA_EXT_PATTERN_PERF_EN
        tests_run++;
        if (ext_stall_cnt_o !== 32'(stalls)) begin
            tests_failed++;
            $display("FAIL %s_stall_cnt: got %0d required %0d", name, ext_stall_cnt_o, stalls);
        end
`endif
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        ext_start_i = 1'b0;
        ext_data_i_valid = 1'b1;
        ext_data_o_ready = 1'b1;
        ext_data_i_bits = '1;
        ext_csr_i_0 = '0; ext_csr_i_1 = '0; ext_csr_i_2 = '0; ext_csr_i_3 = '0;
        step();
        step();
        rst_i = 1'b0;
        step();
        tests_run++;
        if (ext_data_o_valid !== 1'b0 || ext_busy_o !== 1'b0 || ext_data_i_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b required 0/0/0",
                     ext_data_o_valid, ext_busy_o, ext_data_i_ready);
        end
        tests_run++;
        if (ext_data_o_bits !== '0) begin
            tests_failed++;
            $display("FAIL reset_bits: got %h required 0", ext_data_o_bits);
        end
        ext_data_i_valid = 1'b0;
    endtask

    task automatic test_add();
        run_job(32'h10, 32'd1, 2, 1'b0, 8'h00, 100, -1, "add");
        if (got.size() >= 2) begin
            for (int j = 0; j < NW; j++) begin
                tests_run++;
                if (got[0][j*32 +: 32] !== 32'h10 + 32'(j) || got[1][j*32 +: 32] !== 32'h20 + 32'(j)) begin
                    tests_failed++;
                    $display("FAIL add_word%0d: got %h/%h required %h/%h", j, got[0][j*32 +: 32],
                             got[1][j*32 +: 32], 32'h10 + 32'(j), 32'h20 + 32'(j));
                end
            end
        end
    endtask

    task automatic test_xor();
        run_job(32'hFFFF_FFFF, 32'd0, 1, 1'b1, 8'hA5, 100, -1, "xor");
        if (got.size() >= 1) begin
            for (int j = 0; j < NW; j++) begin
                tests_run++;
                if (got[0][j*32 +: 32] !== 32'h5A5A_5A5A) begin
                    tests_failed++;
                    $display("FAIL xor_word%0d: got %h required 5a5a5a5a", j, got[0][j*32 +: 32]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'hFFFF_FFFE; exp_w[1] = 32'hFFFF_FFFF; exp_w[2] = 32'h0000_0000;
        run_job(32'hFFFF_FFFE, 32'd1, 1, 1'b0, 8'h00, 100, -1, "wrap");
        if (got.size() >= 1) begin
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got[0][j*32 +: 32] !== exp_w[j]) begin
                    tests_failed++;
                    $display("FAIL wrap_word%0d: got %h required %h", j, got[0][j*32 +: 32], exp_w[j]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        run_job(32'h0000_1234, 32'h0000_0101, 8, 1'b0, 8'h3C, 50, -1, "bp");
        run_job(32'hCAFE_0000, 32'h0001_0003, 8, 1'b1, 8'h96, 50, -1, "bp_xor");
    endtask

    task automatic test_zero_and_ignored_start();
        int busy_cycles;
        busy_cycles = 0;
        ext_csr_i_0 = 32'h55; ext_csr_i_1 = 32'h1; ext_csr_i_2 = 32'd0; ext_csr_i_3 = 32'd0;
        ext_data_i_valid = 1'b1;
        ext_data_o_ready = 1'b1;
        ext_start_i = 1'b1;
        step();
        ext_start_i = 1'b0;
        tests_run++;
        if (ext_busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_busy_first: got %b required 1", ext_busy_o);
        end
        for (int i = 0; i < 5; i++) begin
            if (ext_busy_o === 1'b1) busy_cycles++;
            tests_run++;
            if (ext_data_o_valid !== 1'b0 || ext_data_i_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_no_beat cyc%0d: valid=%b ready=%b required 0/0", i, ext_data_o_valid, ext_data_i_ready);
            end
            step();
        end
        tests_run++;
        if (busy_cycles != 1) begin
            tests_failed++;
            $display("FAIL zero_busy_len: got %0d cycles required 1", busy_cycles);
        end
        ext_data_i_valid = 1'b0;
        run_job(32'h0000_0500, 32'h10, 3, 1'b1, 8'h77, 100, 1, "restart");
    endtask

    task automatic test_reset_midjob();
        int acc;
        acc = 0;
        ext_csr_i_0 = 32'h100; ext_csr_i_1 = 32'h2; ext_csr_i_2 = 32'd4; ext_csr_i_3 = 32'd0;
        ext_data_i_bits = '0;
        ext_data_i_valid = 1'b0;
        ext_data_o_ready = 1'b0;
        ext_start_i = 1'b1;
        step();
        ext_start_i = 1'b0;
        ext_data_i_valid = 1'b1;
        for (int i = 0; i < 10 && ext_data_i_ready === 1'b1; i++) begin
            step();
            acc++;
        end
        tests_run++;
        if (acc != 2 || ext_data_o_valid !== 1'b1 || ext_busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_fill: accepted %0d valid=%b busy=%b required 2/1/1", acc, ext_data_o_valid, ext_busy_o);
        end
        rst_i = 1'b1;
        step();
        tests_run++;
        if (ext_data_o_valid !== 1'b0 || ext_busy_o !== 1'b0 || ext_data_i_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_clear: valid=%b busy=%b ready=%b required 0/0/0",
                     ext_data_o_valid, ext_busy_o, ext_data_i_ready);
        end
        rst_i = 1'b0;
        ext_data_i_valid = 1'b0;
        ext_data_o_ready = 1'b1;
        step();
        run_job(32'h40, 32'd3, 2, 1'b0, 8'h11, 100, -1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_xor();
        test_wrap();
        test_backpressure();
        test_zero_and_ignored_start();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
